// File: rtl/ts_tx_scheduler_if.sv
// Purpose : bundle of queue-side AXIS, MAC-side AXIS and scheduler status for ts_tx_scheduler.
// Latency : n/a (signal bundle only).
// Backpressure: n/a; modport master = queues/MAC side, modport slave = scheduler side.
// Ports:
//   s_axis_tdata/tvalid/tlast  per-queue AXIS data in (queue i at [i*DATA_WIDTH +: DATA_WIDTH])
//   s_axis_tready              per-queue ready back to queues (only the granted bit may be 1)
//   queue_eligible             per-queue CBS transmit permission
//   m_axis_tdata/tvalid/tlast  AXIS out to MAC, m_axis_tready from MAC
//   cur_queue, busy, frame_overrun  scheduler status
//   gate_open                  802.1Qbv gate state, present only when TS_SCHED_GATE_EN is defined
interface ts_tx_scheduler_if #(
  parameter int NUM_QUEUES = 4,
  parameter int DATA_WIDTH = 8
);
  localparam int QW = $clog2(NUM_QUEUES);

  logic [NUM_QUEUES*DATA_WIDTH-1:0] s_axis_tdata;
  logic [NUM_QUEUES-1:0]            s_axis_tvalid;
  logic [NUM_QUEUES-1:0]            s_axis_tlast;
  logic [NUM_QUEUES-1:0]            s_axis_tready;
  logic [NUM_QUEUES-1:0]            queue_eligible;
  logic [DATA_WIDTH-1:0]            m_axis_tdata;
  logic                             m_axis_tvalid;
  logic                             m_axis_tlast;
  logic                             m_axis_tready;
  logic [QW-1:0]                    cur_queue;
  logic                             busy;
  logic                             frame_overrun;
`ifdef TS_SCHED_GATE_EN
  logic [NUM_QUEUES-1:0]            gate_open;
`endif

  modport master (
`ifdef TS_SCHED_GATE_EN
    output gate_open,
`endif
    output s_axis_tdata, s_axis_tvalid, s_axis_tlast, queue_eligible, m_axis_tready,
    input  s_axis_tready, m_axis_tdata, m_axis_tvalid, m_axis_tlast,
    input  cur_queue, busy, frame_overrun
  );

  modport slave (
`ifdef TS_SCHED_GATE_EN
    input  gate_open,
`endif
    input  s_axis_tdata, s_axis_tvalid, s_axis_tlast, queue_eligible, m_axis_tready,
    output s_axis_tready, m_axis_tdata, m_axis_tvalid, m_axis_tlast,
    output cur_queue, busy, frame_overrun
  );
endinterface

// File: rtl/ts_tx_scheduler.sv
// Purpose : strict-priority egress frame selector between TSN traffic-class queues and the MAC TX AXIS.
// Latency : candidate seen in cycle N -> first beat at N+1; tlast handshake at M -> next grant at M+1, beat at M+2.
// Backpressure: m_axis_tready is routed only to the granted queue; grant held for the whole frame.
// Ports:
//   axis_aclk   clock
//   axis_reset  asynchronous active-high reset
//   bus         ts_tx_scheduler_if.slave (queue AXIS in, MAC AXIS out, cur_queue/busy/frame_overrun)
// Optional feature macro: TS_SCHED_GATE_EN adds bus.gate_open to the candidate mask.
module ts_tx_scheduler #(
  parameter int NUM_QUEUES      = 4,
  parameter int DATA_WIDTH      = 8,
  parameter int MAX_FRAME_BEATS = 1536
) (
  input logic              axis_aclk,
  input logic              axis_reset,
  ts_tx_scheduler_if.slave bus
);
  localparam int QW = $clog2(NUM_QUEUES);
  localparam int CW = $clog2(MAX_FRAME_BEATS + 1);
  localparam logic [CW-1:0] LP_MAX      = CW'(MAX_FRAME_BEATS);
  localparam logic [CW-1:0] LP_MAX_LESS = CW'(MAX_FRAME_BEATS - 1);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_XFER = 1'b1
  } state_t;

  state_t          r_state;
  logic [QW-1:0]   r_cur;
  logic [CW-1:0]   r_cnt;
  logic            r_ovr;

  logic [NUM_QUEUES-1:0] w_cand;
  logic [QW-1:0]         w_sel;
  logic                  w_busy;
  logic                  w_accept;

`ifdef TS_SCHED_GATE_EN
  assign w_cand = bus.s_axis_tvalid & bus.queue_eligible & bus.gate_open;
`else
  assign w_cand = bus.s_axis_tvalid & bus.queue_eligible;
`endif

  // Ascending scan so the highest set index wins (highest priority).
  always_comb begin
    w_sel = '0;
    for (int i = 0; i < NUM_QUEUES; i++) begin
      if (w_cand[i]) w_sel = QW'(i);
    end
  end

  assign w_busy = (r_state == ST_XFER);

  // Output mux is driven only by the registered grant, so m_axis_tvalid has
  // no combinational dependence on m_axis_tready.
  assign bus.m_axis_tdata  = bus.s_axis_tdata[r_cur*DATA_WIDTH +: DATA_WIDTH];
  assign bus.m_axis_tvalid = w_busy & bus.s_axis_tvalid[r_cur];
  assign bus.m_axis_tlast  = w_busy & bus.s_axis_tlast[r_cur];
  assign bus.s_axis_tready = w_busy ? ({{(NUM_QUEUES-1){1'b0}}, bus.m_axis_tready} << r_cur)
                                    : '0;

  assign w_accept = bus.m_axis_tvalid & bus.m_axis_tready;

  assign bus.cur_queue     = r_cur;
  assign bus.busy          = w_busy;
  assign bus.frame_overrun = r_ovr;

  // Arbitration happens only in IDLE: eligibility/gate/priority changes during
  // XFER are ignored so a started frame always completes.
  always_ff @(posedge axis_aclk or posedge axis_reset) begin
    if (axis_reset) begin
      r_state <= ST_IDLE;
      r_cur   <= '0;
      r_cnt   <= '0;
      r_ovr   <= 1'b0;
    end else begin
      r_ovr <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (|w_cand) begin
            r_cur   <= w_sel;
            r_cnt   <= '0;
            r_state <= ST_XFER;
          end
        end
        ST_XFER: begin
          if (w_accept) begin
            // Count saturates, so the overrun pulse can fire only once per frame.
            if (r_cnt != LP_MAX) r_cnt <= r_cnt + CW'(1);
            if (r_cnt == LP_MAX_LESS) r_ovr <= 1'b1;
            if (bus.m_axis_tlast) r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_ts_tx_scheduler.sv
// Purpose : self-checking bench for ts_tx_scheduler (scoreboard of expected MAC beats).
// Latency : n/a.
// Backpressure: bench drives m_axis_tready, including a multi-cycle stall.
module tb_ts_tx_scheduler;
  localparam int NQ   = 4;
  localparam int DW   = 8;
  localparam int MAXB = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ts_tx_scheduler_if #(.NUM_QUEUES(NQ), .DATA_WIDTH(DW)) bus ();

  ts_tx_scheduler #(
    .NUM_QUEUES(NQ), .DATA_WIDTH(DW), .MAX_FRAME_BEATS(MAXB)
  ) dut (
    .axis_aclk (clk),
    .axis_reset(rst),
    .bus       (bus)
  );

  typedef struct {
    logic [7:0] data;
    logic       last;
    logic [1:0] q;
    int         cyc;
  } exp_t;

  exp_t sb[$];
  int n_checks = 0;
  int n_err    = 0;
  int cyc_cnt  = 0;
  int ovr_cnt  = 0;
  int ovr_cyc  = -1;
  int n;
  logic [NQ-1:0] src_act = '0;
  logic [NQ-1:0] elig    = '1;
  logic [NQ-1:0] hs;
  int src_idx[NQ];
  int src_len[NQ];
`ifdef TS_SCHED_GATE_EN
  logic [NQ-1:0] gate = '1;
`endif

  function automatic logic [7:0] beat_data(int q, int i);
    return 8'(q * 32 + i);
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic drive();
    for (int q = 0; q < NQ; q++) begin
      bus.s_axis_tvalid[q]          = src_act[q];
      bus.s_axis_tlast[q]           = src_act[q] && (src_idx[q] == src_len[q] - 1);
      bus.s_axis_tdata[q*DW +: DW]  = beat_data(q, src_idx[q]);
    end
    bus.queue_eligible = elig;
`ifdef TS_SCHED_GATE_EN
    bus.gate_open = gate;
`endif
  endtask

  task automatic start_frame(int q, int len);
    src_act[q] = 1'b1;
    src_idx[q] = 0;
    src_len[q] = len;
    drive();
  endtask

  // first < 0: beat cycles are not checked for this frame
  task automatic expect_frame(int q, int len, int first);
    for (int i = 0; i < len; i++)
      sb.push_back('{beat_data(q, i), (i == len - 1), 2'(q), (first < 0) ? -1 : first + i});
  endtask

  // Sample at negedge, then advance queue sources just after the posedge.
  task automatic cyc();
    exp_t e;
    logic [NQ-1:0] allowed;
    @(negedge clk);
    hs = bus.s_axis_tvalid & bus.s_axis_tready;
    allowed = bus.busy ? (NQ'(1) << bus.cur_queue) : '0;
    chk("tready_route", 32'(bus.s_axis_tready & ~allowed), 0);
    if (!bus.busy) chk("idle_tvalid", 32'(bus.m_axis_tvalid), 0);
    if (bus.frame_overrun) begin
      ovr_cnt++;
      ovr_cyc = cyc_cnt;
    end
    if (bus.m_axis_tvalid && bus.m_axis_tready) begin
      n_checks++;
      assert (sb.size() > 0) else begin
        n_err++;
        $error("FAIL unexpected_beat: observed data %0d, expected no beat", bus.m_axis_tdata);
      end
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("beat_data", 32'(bus.m_axis_tdata), 32'(e.data));
        chk("beat_last", 32'(bus.m_axis_tlast), 32'(e.last));
        chk("beat_queue", 32'(bus.cur_queue), 32'(e.q));
        if (e.cyc >= 0) chk("beat_cycle", cyc_cnt, e.cyc);
      end
    end
    @(posedge clk);
    cyc_cnt++;
    #1;
    for (int q = 0; q < NQ; q++) begin
      if (hs[q]) begin
        if (src_idx[q] == src_len[q] - 1) src_act[q] = 1'b0;
        else src_idx[q] = src_idx[q] + 1;
      end
    end
    drive();
  endtask

  task automatic drain(string tag);
    for (int k = 0; k < 200 && (sb.size() != 0 || src_act != '0); k++) cyc();
    chk({"drain_", tag}, sb.size(), 0);
    chk({"srcs_idle_", tag}, 32'(src_act), 0);
    cyc();
  endtask

  initial begin
    for (int q = 0; q < NQ; q++) begin
      src_idx[q] = 0;
      src_len[q] = 1;
    end
    bus.m_axis_tready = 1'b1;
    drive();

    // Reset held with active inputs
    rst = 1'b1;
    start_frame(3, 4);
    start_frame(1, 4);
    repeat (3) begin
      cyc();
      chk("rst_tvalid", 32'(bus.m_axis_tvalid), 0);
      chk("rst_tready", 32'(bus.s_axis_tready), 0);
      chk("rst_busy", 32'(bus.busy), 0);
      chk("rst_cur", 32'(bus.cur_queue), 0);
      chk("rst_ovr", 32'(bus.frame_overrun), 0);
    end
    src_act = '0;
    drive();
    cyc();
    rst = 1'b0;
    cyc();
    cyc();

    // Strict priority: q3 before q1, exact cycle timing
    start_frame(1, 4);
    start_frame(3, 4);
    n = cyc_cnt;
    expect_frame(3, 4, n + 1);
    expect_frame(1, 4, n + 6);
    cyc();
    chk("pri_grant_q", 32'(bus.cur_queue), 3);
    chk("pri_grant_busy", 32'(bus.busy), 1);
    drain("pri");

    // No preemption: q3 arrives at q0 beat 3
    start_frame(0, 10);
    n = cyc_cnt;
    expect_frame(0, 10, n + 1);
    repeat (4) cyc();
    start_frame(3, 4);
    expect_frame(3, 4, n + 12);
    drain("nopreempt");

    // Eligibility drop mid-frame is ignored
    start_frame(2, 6);
    n = cyc_cnt;
    expect_frame(2, 6, n + 1);
    repeat (3) cyc();
    elig[2] = 1'b0;
    drive();
    drain("elig_drop");

    // Valid but ineligible queue is never granted
    start_frame(2, 3);
    repeat (8) cyc();
    chk("inelig_busy", 32'(bus.busy), 0);
    n = cyc_cnt;
    elig[2] = 1'b1;
    drive();
    expect_frame(2, 3, n + 1);
    drain("inelig");

    // Backpressure: MAC stalls 5 cycles mid-frame
    start_frame(1, 8);
    expect_frame(1, 8, -1);
    repeat (3) cyc();
    bus.m_axis_tready = 1'b0;
    repeat (5) begin
      cyc();
      chk("bp_tdata", 32'(bus.m_axis_tdata), 32'(sb[0].data));
      chk("bp_tready", 32'(bus.s_axis_tready), 0);
      chk("bp_tvalid", 32'(bus.m_axis_tvalid), 1);
      chk("bp_cur", 32'(bus.cur_queue), 1);
    end
    bus.m_axis_tready = 1'b1;
    drain("bp");

    chk("ovr_none_short_frames", ovr_cnt, 0);

    // Overrun: 20-beat frame with limit 16
    ovr_cnt = 0;
    start_frame(0, 20);
    n = cyc_cnt;
    expect_frame(0, 20, n + 1);
    drain("overrun");
    chk("ovr_pulses", ovr_cnt, 1);
    chk("ovr_cycle", ovr_cyc, n + 17);

    // Asynchronous reset mid-frame
    start_frame(2, 6);
    expect_frame(2, 6, -1);
    repeat (3) cyc();
    #2 rst = 1'b1;
    #1;
    chk("arst_busy", 32'(bus.busy), 0);
    chk("arst_tvalid", 32'(bus.m_axis_tvalid), 0);
    chk("arst_tready", 32'(bus.s_axis_tready), 0);
    chk("arst_cur", 32'(bus.cur_queue), 0);
    src_act = '0;
    sb.delete();
    drive();
    cyc();
    cyc();
    rst = 1'b0;
    cyc();
    start_frame(1, 2);
    n = cyc_cnt;
    expect_frame(1, 2, n + 1);
    drain("post_reset");

`ifdef TS_SCHED_GATE_EN
    // Closed gate excludes q3 until reopened
    gate[3] = 1'b0;
    start_frame(3, 4);
    start_frame(1, 4);
    n = cyc_cnt;
    expect_frame(1, 4, n + 1);
    expect_frame(3, 4, n + 6);
    cyc();
    cyc();
    gate[3] = 1'b1;
    drive();
    drain("gate");
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end
endmodule
